exec_fsm: RTL and testbench

- Execute-stage control sequencer. Sits directly downstream of the instruction-fetch FSM.
- Starts when fetch has loaded IR. Decodes the 4-bit opcode and issues single-bus datapath control strobes (register file, ALU, MAR/MDR, memory, PC) one cycle at a time.
- Ends every instruction with a one-cycle done pulse, which restarts fetch.
- Memory accesses use the same MFC wait handshake as fetch, plus a timeout.

---
 rtl/exec_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_exec_fsm.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/exec_fsm.sv
// Execute-stage control sequencer: decodes the IR opcode and issues single-bus
// datapath strobes one state at a time, ending each instruction with a done pulse.
module exec_fsm #(
    parameter int unsigned MFC_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       MFC,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       PC_inc,
    output logic       PC_load,
    output logic       IR_addr_out,
    output logic       rsel,
    output logic       reg_out,
    output logic       reg_in,
    output logic       A_EN,
    output logic [1:0] alu_op,
    output logic       G_EN,
    output logic       G_out,
    output logic       MAR_EN,
    output logic       mem_EN,
    output logic       mem_RW,
    output logic       MDR_EN_read,
    output logic       MDR_EN_write,
    output logic       MDR_out
);

    typedef enum logic [4:0] {
        StIdle,
        StDec,
        StLdAddr,
        StLdReq,
        StLdWait,
        StLdCap,
        StLdWb,
        StStAddr,
        StStData,
        StStReq,
        StStWait,
        StAlA,
        StAlOpAdd,
        StAlOpSub,
        StAlWb,
        StJmp,
        StMov,
        StDone,
        StDoneErr
    } state_e;

    // ADD/SUB and the error flag are folded into distinct states so every
    // output stays a pure decode of the state register.
    localparam logic [7:0] LastCnt = 8'(MFC_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: if (start) state_d = StDec;
            StDec: begin
                unique case (opcode)
                    4'd0:       state_d = StDone;
                    4'd1:       state_d = StLdAddr;
                    4'd2:       state_d = StStAddr;
                    4'd3, 4'd4: state_d = StAlA;
                    4'd5:       state_d = StJmp;
                    4'd6:       state_d = StMov;
                    default:    state_d = StDoneErr;
                endcase
            end
            StLdAddr: state_d = StLdReq;
            StLdReq:  state_d = StLdWait;
            StLdWait: begin
                if (MFC) begin
                    state_d = StLdCap;
                end else if (cnt_q == LastCnt) begin
                    state_d = StDoneErr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StLdCap:  state_d = StLdWb;
            StLdWb:   state_d = StDone;
            StStAddr: state_d = StStData;
            StStData: state_d = StStReq;
            StStReq:  state_d = StStWait;
            StStWait: begin
                if (MFC) begin
                    state_d = StDone;
                end else if (cnt_q == LastCnt) begin
                    state_d = StDoneErr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StAlA:     state_d = (opcode == 4'd4) ? StAlOpSub : StAlOpAdd;
            StAlOpAdd: state_d = StAlWb;
            StAlOpSub: state_d = StAlWb;
            StAlWb:    state_d = StDone;
            StJmp:     state_d = StDone;
            StMov:     state_d = StDone;
            StDone:    state_d = StIdle;
            StDoneErr: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        done         = 1'b0;
        err          = 1'b0;
        PC_inc       = 1'b0;
        PC_load      = 1'b0;
        IR_addr_out  = 1'b0;
        rsel         = 1'b0;
        reg_out      = 1'b0;
        reg_in       = 1'b0;
        A_EN         = 1'b0;
        alu_op       = 2'b00;
        G_EN         = 1'b0;
        G_out        = 1'b0;
        MAR_EN       = 1'b0;
        mem_EN       = 1'b0;
        mem_RW       = 1'b0;
        MDR_EN_read  = 1'b0;
        MDR_EN_write = 1'b0;
        MDR_out      = 1'b0;
        unique case (state_q)
            StDec: PC_inc = 1'b1;
            StLdAddr, StStAddr: begin
                IR_addr_out = 1'b1;
                MAR_EN      = 1'b1;
            end
            StLdReq, StLdWait: begin
                mem_EN = 1'b1;
                mem_RW = 1'b1;
            end
            StLdCap: begin
                mem_EN      = 1'b1;
                mem_RW      = 1'b1;
                MDR_EN_read = 1'b1;
            end
            StLdWb: begin
                MDR_out = 1'b1;
                reg_in  = 1'b1;
            end
            StStData: begin
                reg_out      = 1'b1;
                MDR_EN_write = 1'b1;
            end
            StStReq, StStWait: mem_EN = 1'b1;
            StAlA: begin
                reg_out = 1'b1;
                A_EN    = 1'b1;
            end
            StAlOpAdd, StAlOpSub: begin
                rsel    = 1'b1;
                reg_out = 1'b1;
                G_EN    = 1'b1;
                alu_op  = (state_q == StAlOpSub) ? 2'b01 : 2'b00;
            end
            StAlWb: begin
                G_out  = 1'b1;
                reg_in = 1'b1;
            end
            StJmp: begin
                IR_addr_out = 1'b1;
                PC_load     = 1'b1;
            end
            StMov: begin
                rsel    = 1'b1;
                reg_out = 1'b1;
                reg_in  = 1'b1;
            end
            StDone: done = 1'b1;
            StDoneErr: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exec_fsm.sv
// Directed bench for exec_fsm: per-cycle expected strobe vectors for each opcode,
// wait/timeout handling, start-while-busy and asynchronous reset.
module tb_exec_fsm;

    logic       clk = 1'b0;
    logic       rst, start, MFC;
    logic [3:0] opcode;
    logic       busy, done, err, PC_inc, PC_load, IR_addr_out, rsel, reg_out, reg_in;
    logic       A_EN, G_EN, G_out, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_EN_write, MDR_out;
    logic [1:0] alu_op;

    always #5 clk = ~clk;

    exec_fsm #(.MFC_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .MFC(MFC),
        .busy(busy), .done(done), .err(err), .PC_inc(PC_inc), .PC_load(PC_load),
        .IR_addr_out(IR_addr_out), .rsel(rsel), .reg_out(reg_out), .reg_in(reg_in),
        .A_EN(A_EN), .alu_op(alu_op), .G_EN(G_EN), .G_out(G_out), .MAR_EN(MAR_EN),
        .mem_EN(mem_EN), .mem_RW(mem_RW), .MDR_EN_read(MDR_EN_read),
        .MDR_EN_write(MDR_EN_write), .MDR_out(MDR_out)
    );

    localparam logic [19:0] BUSY = 20'h80000, DONE = 20'h40000, ERR  = 20'h20000;
    localparam logic [19:0] PCI  = 20'h10000, PCL  = 20'h08000, IRA  = 20'h04000;
    localparam logic [19:0] RSEL = 20'h02000, RO   = 20'h01000, RI   = 20'h00800;
    localparam logic [19:0] AEN  = 20'h00400, ALU0 = 20'h00100;
    localparam logic [19:0] GEN  = 20'h00080, GO   = 20'h00040, MAR  = 20'h00020;
    localparam logic [19:0] MEN  = 20'h00010, MRW  = 20'h00008, MDRR = 20'h00004;
    localparam logic [19:0] MDRW = 20'h00002, MDRO = 20'h00001;

    localparam logic [19:0] E_IDLE  = 20'h0;
    localparam logic [19:0] E_DEC   = BUSY | PCI;
    localparam logic [19:0] E_DONE  = BUSY | DONE;
    localparam logic [19:0] E_DERR  = BUSY | DONE | ERR;
    localparam logic [19:0] E_ADDR  = BUSY | IRA | MAR;
    localparam logic [19:0] E_LDREQ = BUSY | MEN | MRW;
    localparam logic [19:0] E_LDCAP = BUSY | MEN | MRW | MDRR;
    localparam logic [19:0] E_LDWB  = BUSY | MDRO | RI;
    localparam logic [19:0] E_STDAT = BUSY | RO | MDRW;
    localparam logic [19:0] E_STREQ = BUSY | MEN;
    localparam logic [19:0] E_ALA   = BUSY | RO | AEN;
    localparam logic [19:0] E_ADD   = BUSY | RSEL | RO | GEN;
    localparam logic [19:0] E_SUB   = BUSY | RSEL | RO | GEN | ALU0;
    localparam logic [19:0] E_ALWB  = BUSY | GO | RI;
    localparam logic [19:0] E_JMP   = BUSY | IRA | PCL;
    localparam logic [19:0] E_MOV   = BUSY | RSEL | RO | RI;

    logic [19:0] ctrl;
    assign ctrl = {busy, done, err, PC_inc, PC_load, IR_addr_out, rsel, reg_out, reg_in,
                   A_EN, alu_op, G_EN, G_out, MAR_EN, mem_EN, mem_RW, MDR_EN_read,
                   MDR_EN_write, MDR_out};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] exp_q[$];
    bit          mfc_q[$];
    bit          st_q[$];

    task automatic add(input logic [19:0] e, input bit m, input bit s);
        exp_q.push_back(e);
        mfc_q.push_back(m);
        st_q.push_back(s);
    endtask

    // Pulse start with op, then walk the queued per-cycle expectations.
    task automatic run(input string name, input logic [3:0] op);
        opcode = op;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s c%0d", name, i + 1), 32'(ctrl), 32'(exp_q[i]));
            check($sformatf("%s bus c%0d", name, i + 1),
                  32'($countones({IR_addr_out, reg_out, MDR_out, G_out}) <= 1), 32'd1);
            MFC   = mfc_q[i];
            start = st_q[i];
            tick();
            start = 1'b0;
        end
        exp_q.delete();
        mfc_q.delete();
        st_q.delete();
        MFC = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        MFC    = 1'b0;
        opcode = 4'd0;
        tick();
        check("reset outputs", 32'(ctrl), 32'(E_IDLE));
        #4 rst = 1'b0;
        tick();
        check("idle after reset", 32'(ctrl), 32'(E_IDLE));

        add(E_DEC, 0, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("nop", 4'd0);

        // LOAD, three MFC=0 wait cycles; MFC high in non-wait states must be ignored
        add(E_DEC, 1, 0); add(E_ADDR, 1, 0); add(E_LDREQ, 1, 0);
        add(E_LDREQ, 0, 0); add(E_LDREQ, 0, 0); add(E_LDREQ, 0, 0); add(E_LDREQ, 1, 0);
        add(E_LDCAP, 1, 0); add(E_LDWB, 1, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("load w3", 4'd1);

        add(E_DEC, 0, 0); add(E_ADDR, 0, 0); add(E_STDAT, 0, 0); add(E_STREQ, 1, 0);
        add(E_STREQ, 1, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("store w0", 4'd2);

        add(E_DEC, 0, 0); add(E_ALA, 0, 0); add(E_SUB, 0, 0); add(E_ALWB, 0, 0);
        add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("sub", 4'd4);

        // start pulses while busy must not spawn a second instruction
        add(E_DEC, 0, 1); add(E_ALA, 0, 1); add(E_ADD, 0, 0); add(E_ALWB, 0, 0);
        add(E_DONE, 0, 0); add(E_IDLE, 0, 0); add(E_IDLE, 0, 0);
        run("add busy-start", 4'd3);

        add(E_DEC, 0, 0); add(E_JMP, 0, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("jmp", 4'd5);

        add(E_DEC, 0, 0); add(E_MOV, 0, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("mov", 4'd6);

        add(E_DEC, 0, 0); add(E_DERR, 0, 0); add(E_IDLE, 0, 0);
        run("illegal 9", 4'd9);

        add(E_DEC, 0, 0); add(E_DERR, 0, 0); add(E_IDLE, 0, 0);
        run("illegal 7", 4'd7);

        // timeout at 4 wait cycles; err flag must not stick into the next instruction
        add(E_DEC, 0, 0); add(E_ADDR, 0, 0); add(E_LDREQ, 0, 0);
        add(E_LDREQ, 0, 0); add(E_LDREQ, 0, 0); add(E_LDREQ, 0, 0); add(E_LDREQ, 0, 0);
        add(E_DERR, 0, 0); add(E_IDLE, 0, 0);
        run("load timeout", 4'd1);

        add(E_DEC, 0, 0); add(E_ADDR, 0, 0); add(E_STDAT, 0, 0); add(E_STREQ, 0, 0);
        add(E_STREQ, 0, 0); add(E_STREQ, 0, 0); add(E_STREQ, 0, 0); add(E_STREQ, 0, 0);
        add(E_DERR, 0, 0); add(E_IDLE, 0, 0);
        run("store timeout", 4'd2);

        add(E_DEC, 0, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("nop after err", 4'd0);

        // asynchronous reset in LD_WAIT
        opcode = 4'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre-rst ld_wait", 32'(ctrl), 32'(E_LDREQ));
        #2 rst = 1'b1;
        #1 check("async rst", 32'(ctrl), 32'(E_IDLE));
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MFC = 1'b1;
            tick();
            check($sformatf("post-rst idle c%0d", i), 32'(ctrl), 32'(E_IDLE));
        end
        MFC = 1'b0;

        add(E_DEC, 0, 0); add(E_DONE, 0, 0); add(E_IDLE, 0, 0);
        run("nop after rst", 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
